// File: rtl/branch_pkg.sv
// Shared types and constants for the branch/jump sequencing controller.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; 1-cycle update latency.
// No backpressure: holds at all-ones once reached, cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump sequencer: accept 1 cycle, resolve >=1 cycle, redirect until fetch accepts.
// Backpressure: br_ready low while busy and in the br_done cycle; redirect holds until redir_ready.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [XLEN-1:0]  br_instr,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    output logic [XLEN-1:0]  eu_instr,
    output logic [XLEN-1:0]  eu_pc,
    output logic [XLEN-1:0]  eu_imm,
    input  logic             eu_accept,
    input  logic             eu_wait,
    input  logic [XLEN-1:0]  eu_addr,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_addr,
    output logic             flush,
    output logic             stall_if,
    output logic             br_done,
    output logic             br_taken,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state, state_nxt;
    logic   latch_in, latch_addr, stall_inc;
    logic   done_nxt, taken_nxt, flush_nxt;

    // br_done gating keeps a resolved branch from overlapping the next accept.
    assign br_ready    = (state == IDLE) && !br_done;
    assign stall_if    = (state != IDLE);
    assign redir_valid = (state == REDIRECT);

    always_comb begin
        state_nxt  = state;
        latch_in   = 1'b0;
        latch_addr = 1'b0;
        stall_inc  = 1'b0;
        done_nxt   = 1'b0;
        taken_nxt  = 1'b0;
        flush_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (br_valid && br_ready) begin
                    latch_in  = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (eu_wait) begin
                    stall_inc = 1'b1;
                end else if (eu_accept) begin
                    latch_addr = 1'b1;
                    state_nxt  = REDIRECT;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            REDIRECT: begin
                if (redir_ready) begin
                    flush_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    taken_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            eu_instr   <= '0;
            eu_pc      <= '0;
            eu_imm     <= '0;
            redir_addr <= '0;
            flush      <= 1'b0;
            br_done    <= 1'b0;
            br_taken   <= 1'b0;
        end else begin
            state    <= state_nxt;
            flush    <= flush_nxt;
            br_done  <= done_nxt;
            br_taken <= taken_nxt;
            if (latch_in) begin
                eu_instr <= br_instr;
                eu_pc    <= br_pc;
                eu_imm   <= br_imm;
            end
            if (latch_addr) begin
                redir_addr <= eu_addr;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with a transaction-level reference model.
module tb_branch_ctrl;
    import branch_pkg::*;

    localparam int XLEN  = 32;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            br_valid = 1'b0;
    logic            br_ready;
    logic [XLEN-1:0] br_instr = '0, br_pc = '0, br_imm = '0;
    logic [XLEN-1:0] eu_instr, eu_pc, eu_imm;
    logic            eu_accept = 1'b0, eu_wait = 1'b0;
    logic [XLEN-1:0] eu_addr = '0;
    logic            redir_valid;
    logic            redir_ready = 1'b0;
    logic [XLEN-1:0] redir_addr;
    logic            flush, stall_if, br_done, br_taken;
    logic [CW-1:0]   stall_cnt;

    int checks = 0;
    int failures = 0;
    int accepts = 0;
    bit in_t4 = 1'b0;

    always #5 clk = ~clk;

    branch_ctrl #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready),
        .br_instr(br_instr), .br_pc(br_pc), .br_imm(br_imm),
        .eu_instr(eu_instr), .eu_pc(eu_pc), .eu_imm(eu_imm),
        .eu_accept(eu_accept), .eu_wait(eu_wait), .eu_addr(eu_addr),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_addr(redir_addr),
        .flush(flush), .stall_if(stall_if),
        .br_done(br_done), .br_taken(br_taken), .stall_cnt(stall_cnt)
    );

    // Reference model: busy phase 0 = free, 1 = resolving, 2 = waiting on fetch.
    int        m_phase = 0;
    int        m_cnt = 0;
    bit        m_done = 0, m_taken = 0, m_flush = 0;
    logic [31:0] m_instr = '0, m_pc = '0, m_imm = '0, m_addr = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_cnt <= 0;
            m_done <= 0; m_taken <= 0; m_flush <= 0;
            m_instr <= '0; m_pc <= '0; m_imm <= '0; m_addr <= '0;
        end else begin
            m_done <= 0; m_taken <= 0; m_flush <= 0;
            if (m_phase == 0) begin
                if (br_valid && !m_done) begin
                    m_instr <= br_instr; m_pc <= br_pc; m_imm <= br_imm;
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (eu_wait) begin
                    m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                end else if (eu_accept) begin
                    m_addr <= eu_addr;
                    m_phase <= 2;
                end else begin
                    m_done <= 1;
                    m_phase <= 0;
                end
            end else if (redir_ready) begin
                m_done <= 1; m_taken <= 1; m_flush <= 1;
                m_phase <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("br_ready",    32'(br_ready),    32'(m_phase == 0 && !m_done));
        chk("stall_if",    32'(stall_if),    32'(m_phase != 0));
        chk("redir_valid", 32'(redir_valid), 32'(m_phase == 2));
        chk("redir_addr",  redir_addr,       m_addr);
        chk("flush",       32'(flush),       32'(m_flush));
        chk("br_done",     32'(br_done),     32'(m_done));
        chk("br_taken",    32'(br_taken),    32'(m_taken));
        chk("eu_instr",    eu_instr,         m_instr);
        chk("eu_pc",       eu_pc,            m_pc);
        chk("eu_imm",      eu_imm,           m_imm);
        chk("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
        if (in_t4 && br_valid && br_ready) accepts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm);
        br_valid = 1'b1; br_instr = ins; br_pc = pc; br_imm = imm;
    endtask

    initial begin
        bit got;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // 1: JAL taken, fetch ready immediately
        present(32'h0080006F, 32'h100, 32'h8);
        eu_accept = 1'b1; eu_wait = 1'b0; eu_addr = 32'h108; redir_ready = 1'b1;
        tick();
        br_valid = 1'b0;
        chk("t1_eu_pc", eu_pc, 32'h100);
        tick();
        chk("t1_redir_valid", 32'(redir_valid), 32'd1);
        chk("t1_redir_addr", redir_addr, 32'h108);
        tick();
        chk("t1_flush", 32'(flush), 32'd1);
        chk("t1_done_taken", {30'd0, br_done, br_taken}, 32'd3);
        chk("t1_ready_low", 32'(br_ready), 32'd0);
        tick();
        chk("t1_flush_clear", 32'(flush), 32'd0);
        chk("t1_ready_back", 32'(br_ready), 32'd1);

        // 2: BEQ with 5 wait cycles, then not taken
        present({25'h0104, OP_BRANCH}, 32'h200, 32'h10);
        eu_wait = 1'b1; eu_accept = 1'b1; redir_ready = 1'b0;
        tick();
        br_valid = 1'b0;
        repeat (5) tick();
        eu_wait = 1'b0; eu_accept = 1'b0;
        tick();
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("t2_done_nt", {30'd0, br_done, br_taken}, 32'd2);
        chk("t2_no_flush", 32'(flush), 32'd0);
        tick();

        // 3: JALR taken, fetch stalls the redirect for 4 cycles
        present({25'h000081, OP_JALR}, 32'h300, 32'h0);
        eu_accept = 1'b1; eu_addr = 32'h404; redir_ready = 1'b0;
        tick();
        br_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t3_hold_valid", 32'(redir_valid), 32'd1);
            chk("t3_hold_addr", redir_addr, 32'h404);
            chk("t3_no_flush", 32'(flush), 32'd0);
            if (k < 3) tick();
        end
        redir_ready = 1'b1;
        tick();
        chk("t3_flush", 32'(flush), 32'd1);
        tick();

        // 4: br_valid held, alternating taken / not taken (incl. non-branch opcode)
        in_t4 = 1'b1;
        eu_wait = 1'b0; redir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: br_instr = {25'h0, OP_JAL};
                1: br_instr = 32'h00000033;
                2: br_instr = {25'h0, OP_BRANCH};
                default: br_instr = {25'h0, OP_JALR};
            endcase
            br_valid = 1'b1; br_pc = 32'h400 + 32'(i * 4); br_imm = 32'(i);
            eu_accept = (i % 2 == 0); eu_addr = 32'h800 + 32'(i * 16);
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                tick();
                if (br_done) got = 1'b1;
            end
            chk("t4_done_seen", 32'(got), 32'd1);
            chk("t4_taken", 32'(br_taken), 32'(i % 2 == 0));
        end
        br_valid = 1'b0;
        in_t4 = 1'b0;
        chk("t4_accepts", 32'(accepts), 32'd4);
        tick();

        // 5: reset asserted during REDIRECT
        present({25'h0, OP_JAL}, 32'h500, 32'h20);
        eu_accept = 1'b1; eu_addr = 32'h520; redir_ready = 1'b0;
        tick();
        br_valid = 1'b0;
        tick();
        chk("t5_in_redirect", 32'(redir_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(redir_valid), 32'd0);
        chk("t5_async_flush", 32'(flush), 32'd0);
        chk("t5_async_stall", 32'(stall_if), 32'd0);
        eu_accept = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("t5_ready", 32'(br_ready), 32'd1);
        chk("t5_eu_pc", eu_pc, 32'h0);

        // 6: 20 wait cycles saturate the 4-bit counter at 15
        present({25'h0, OP_BRANCH}, 32'h600, 32'h4);
        eu_wait = 1'b1;
        tick();
        br_valid = 1'b0;
        repeat (20) tick();
        chk("t6_saturated", 32'(stall_cnt), 32'd15);
        eu_wait = 1'b0; eu_accept = 1'b0;
        tick();
        chk("t6_done", 32'(br_done), 32'd1);
        chk("t6_still_sat", 32'(stall_cnt), 32'd15);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Sequencing controller for the branch/jump execute unit. It accepts one control-flow instruction at a time from decode and drives the registered instruction, PC and immediate into the execute unit. It holds that instruction while the scoreboard reports operand dependencies, then either issues a PC redirect plus a front-end flush (taken) or retires it silently (not taken). Between decode/scoreboard and fetch, it stalls fetch while a branch is unresolved.

Parameters:
XLEN, 32, width of instruction, PC, immediate and target address
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
br_valid  input  1  decode presents a control-flow instruction
br_ready  output  1  controller can accept an instruction this cycle
br_instr  input  XLEN  raw instruction word
br_pc  input  XLEN  instruction PC
br_imm  input  XLEN  decoded immediate
eu_instr  output  XLEN  registered instruction to execute unit
eu_pc  output  XLEN  registered PC to execute unit
eu_imm  output  XLEN  registered immediate to execute unit
eu_accept  input  1  execute unit: jump/branch taken
eu_wait  input  1  execute unit: required operand not yet valid
eu_addr  input  XLEN  execute unit: target address
redir_valid  output  1  redirect request to fetch
redir_ready  input  1  fetch accepts redirect
redir_addr  output  XLEN  redirect target
flush  output  1  one-cycle pulse: kill younger instructions in fetch/decode
stall_if  output  1  hold fetch PC while a branch is in flight
br_done  output  1  one-cycle pulse: instruction resolved
br_taken  output  1  qualifies br_done: 1 = taken
stall_cnt  output  CNT_W  saturating count of cycles spent in EVAL with eu_wait=1

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. All flops reset asynchronously.
- Reset values: state=IDLE; eu_instr/eu_pc/eu_imm=0; redir_addr=0; redir_valid, flush, br_done, br_taken=0; stall_cnt=0. br_ready=1 and stall_if=0 follow from IDLE.
- States: IDLE, EVAL, REDIRECT. Encoding lives in the package.
- IDLE:
  - br_ready=1, stall_if=0.
  - On br_valid, latch br_instr/br_pc/br_imm into eu_* and go to EVAL. Accept latency is 1 cycle.
- EVAL:
  - br_ready=0, stall_if=1. eu_* are held stable. eu_accept, eu_wait and eu_addr are sampled every cycle.
  - eu_wait=1: stay in EVAL and increment stall_cnt. eu_accept is ignored while eu_wait=1.
  - eu_wait=0, eu_accept=1: latch eu_addr into redir_addr and go to REDIRECT.
  - eu_wait=0, eu_accept=0: pulse br_done=1 with br_taken=0 and return to IDLE.
  - A non-control-flow opcode yields accept=0/wait=0 and retires as not-taken in 1 cycle. This is legal, not an error.
- REDIRECT:
  - redir_valid=1, redir_addr stable, stall_if=1, br_ready=0.
  - redir_valid must not drop before the handshake completes.
  - On redir_valid & redir_ready, the same cycle's registered outputs on the next edge are: flush=1 for exactly one cycle, br_done=1, br_taken=1, redir_valid=0. State returns to IDLE.
- Throughput:
  - Minimum 2 cycles per not-taken branch (IDLE→EVAL→IDLE).
  - Minimum 3 cycles per taken branch with redir_ready held high.
  - No back-to-back accept: br_ready is low in the cycle br_done pulses. The next accept is possible one cycle later.
- stall_cnt saturates at all-ones and never wraps. It is only cleared by reset.
- eu_wait asserted indefinitely keeps the controller in EVAL. There is no timeout.
- Reset mid-operation returns to IDLE immediately. No flush or redirect is emitted, and the in-flight branch is discarded.
- br_valid while br_ready=0 is ignored. Decode must hold the instruction.

Decomposition:
- Shared package branch_pkg holds:
  - state enum/localparams (IDLE=2'd0, EVAL=2'd1, REDIRECT=2'd2)
  - opcode constants: BRANCH 7'b1100011, JAL 7'b1101111, JALR 7'b1100111
- Optional sub-module: sat_counter (parameterised width, increment enable, saturate). It is reusable for other scoreboard performance counters.

Test Plan:
1. JAL 0x0080006F at pc=0x100, imm=0x8: eu_accept=1, eu_addr=0x108, wait=0, redir_ready=1 → redir_valid for 1 cycle with addr 0x108, flush pulse, br_done & br_taken, back in IDLE 3 cycles after accept.
2. BEQ with eu_wait=1 for 5 cycles, then eu_wait=0, eu_accept=0 → stall_if high for 6 cycles, stall_cnt=5, br_done=1 with br_taken=0, no flush, no redir_valid.
3. JALR taken, redir_ready low for 4 cycles → redir_valid and redir_addr stable for all 4 cycles, flush only after ready=1.
4. br_valid held high continuously with alternating taken/not-taken → each instruction accepted exactly once, br_ready low throughout EVAL/REDIRECT.
5. rst_n low during REDIRECT with redir_valid=1 → redir_valid=0, flush=0 asynchronously, state IDLE, br_ready=1 after release.
6. Force stall_cnt near max (CNT_W=4, 20 wait cycles) → counter stops at 15, does not wrap.
